// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package mem_ctrl_pkg;

  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } owner_e;

  // Counter preload for a given read latency, clamped to the counter range.
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int mem_lat);
    int lat_v;
    if (mem_lat > MEM_LAT_MAX) begin
      lat_v = MEM_LAT_MAX;
    end else if (mem_lat < 1) begin
      lat_v = 1;
    end else begin
      lat_v = mem_lat;
    end
    return LAT_CNT_W'(lat_v - 1);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the memory read latency; zero_o flags that
// the count reaches zero at the coming edge.
module mem_lat_counter import mem_ctrl_pkg::*; (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement, saturate at zero.
  always_comb begin
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {LAT_CNT_W{1'b0}})) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {LAT_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_d == {LAT_CNT_W{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns EX/MEM MemRd/MemWr strobes into a fixed-latency memory handshake and
// stalls the pipeline until done. Define DBG_PORT_EN to add a debug requester.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef DBG_PORT_EN
  ,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_done
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic                cpu_req_s;
  logic                enter_done_s;
  logic                cnt_zero_s;

  assign cpu_req_s = cpu_rd | cpu_wr;

  mem_lat_counter u_lat_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (state_q == ISSUE),
    .load_val_i (LAT_LOAD),
    .dec_i      (state_q == WAIT),
    .zero_o     (cnt_zero_s)
  );

`ifdef DBG_PORT_EN
  owner_e      prio_q, prio_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        dbg_done_q, dbg_done_d;
  logic        grant_dbg_s;

  assign grant_dbg_s = dbg_req & (~cpu_req_s | (prio_q == DBG));
`endif

  // Sequencer next state and access register updates.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    enter_done_s = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef DBG_PORT_EN
        if (grant_dbg_s) begin
          owner_d     = DBG;
          mem_we_d    = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else
`endif
        if (cpu_req_s) begin
          owner_d     = CPU;
          mem_we_d    = cpu_wr;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (MEM_LAT == 1) begin
          state_d      = DONE;
          enter_done_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero_s) begin
          state_d      = DONE;
          enter_done_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data is sampled on the edge that enters DONE; stores leave it alone.
    if (enter_done_s && !mem_we_q && (owner_q == CPU)) begin
      cpu_rdata_d = mem_rdata;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
  end

  // Sequencer and access registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= CPU;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      cpu_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

`ifdef DBG_PORT_EN
  // Debug completion, debug read data and round-robin priority.
  always_comb begin
    dbg_rdata_d = dbg_rdata_q;
    dbg_done_d  = 1'b0;
    prio_d      = prio_q;
    if (enter_done_s && (owner_q == DBG)) begin
      dbg_done_d = 1'b1;
      if (!mem_we_q) begin
        dbg_rdata_d = mem_rdata;
      end else begin
        dbg_rdata_d = dbg_rdata_q;
      end
    end else begin
      dbg_done_d = 1'b0;
    end
    if (mem_en_d) begin
      prio_d = (prio_q == CPU) ? DBG : CPU;
    end else begin
      prio_d = prio_q;
    end
  end

  // Debug-side registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_rdata_q <= 32'h0000_0000;
      dbg_done_q  <= 1'b0;
      prio_q      <= CPU;
    end else begin
      dbg_rdata_q <= dbg_rdata_d;
      dbg_done_q  <= dbg_done_d;
      prio_q      <= prio_d;
    end
  end

  assign dbg_rdata = dbg_rdata_q;
  assign dbg_done  = dbg_done_q;
`endif

  // Released on the CPU's own DONE cycle so EX/MEM advances exactly once.
  assign stall     = reset & cpu_req_s & ~((state_q == DONE) & (owner_q == CPU));
  assign cpu_rdata = cpu_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: MEM_LAT=2 main instance plus a
// MEM_LAT=1 instance; debug arbitration exercised when DBG_PORT_EN is defined.
module tb_mem_access_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [7:0]  len;
  } done_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        c1_rd;
  logic [31:0] c1_addr, cpu_rdata1;
  logic        stall1, mem_en1, mem_we1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_done;

  logic [31:0] mem_arr [0:63];
  acc_t        acc_q [$];
  done_t       done_q [$];
  done_t       q1 [$];
  logic [31:0] dbg_q [$];
  int          en_times [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          age = 15;
  int          age1 = 15;
  int          run = 0;
  int          run1 = 0;
  int          en1_cnt = 0;
  logic        dbg_prev = 1'b0;
  acc_t        e;
  done_t       d;
  logic [31:0] dv;
  int          n0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DBG_PORT_EN
    , .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done)
`endif
  );

  mem_access_ctrl #(.MEM_LAT(1), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset), .cpu_rd(c1_rd), .cpu_wr(1'b0),
    .cpu_addr(c1_addr), .cpu_wdata(32'h0000_0000), .cpu_rdata(cpu_rdata1),
    .stall(stall1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
`ifdef DBG_PORT_EN
    , .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0000_0000),
    .dbg_wdata(32'h0000_0000), .dbg_rdata(), .dbg_done()
`endif
  );

`ifndef DBG_PORT_EN
  assign dbg_done  = 1'b0;
  assign dbg_rdata = 32'h0000_0000;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory models: data valid only in the cycle MEM_LAT-1 after the strobe.
  always @(negedge clk) begin
    if (mem_en) age = 0; else if (age < 15) age++;
    if (mem_en && mem_we) mem_arr[mem_addr[7:2]] = mem_wdata;
    mem_rdata = (age == 1) ? mem_arr[mem_addr[7:2]] : 32'hBAD0_BAD0;
    if (mem_en1) age1 = 0; else if (age1 < 15) age1++;
    mem_rdata1 = (age1 == 0) ? (32'h5A5A_0000 | mem_addr1) : 32'hBAD0_BAD0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUTs present an event.
  always @(negedge clk) begin
    if (!reset) begin
      run = 0;
      run1 = 0;
    end else begin
      if (mem_en) begin
        en_times.push_back(cyc);
        chk("access_expected", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          e = acc_q.pop_front();
          chk("acc_we", mem_we, e.we);
          chk("acc_addr", mem_addr, e.addr);
          if (e.we) chk("acc_wdata", mem_wdata, e.wdata);
        end
      end
      if (!(cpu_rd | cpu_wr)) run = 0;
      else if (stall) run++;
      else begin
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("cpu_rdata", cpu_rdata, d.rdata);
          chk("stall_cycles", run, d.len);
        end
        run = 0;
      end
      if (mem_en1) en1_cnt++;
      if (!c1_rd) run1 = 0;
      else if (stall1) run1++;
      else begin
        chk("lat1_done_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          d = q1.pop_front();
          chk("lat1_rdata", cpu_rdata1, d.rdata);
          chk("lat1_stall_cycles", run1, d.len);
        end
        run1 = 0;
      end
      if (dbg_done) begin
        chk("dbg_done_pulse", dbg_prev, 0);
        chk("dbg_expected", dbg_q.size() != 0, 1);
        if (dbg_q.size() != 0) begin
          dv = dbg_q.pop_front();
          chk("dbg_rdata", dbg_rdata, dv);
        end
      end
    end
    dbg_prev = dbg_done;
  end

  task automatic wait_for(input int sel, input string nm);
    int n;
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? !stall : ((sel == 1) ? !stall1 : dbg_done);
    end while (!hit && n < 40);
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles", nm, n);
    end
  endtask

  task automatic do_cpu(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    acc_q.push_back('{we: wr, addr: addr, wdata: wdata});
    done_q.push_back('{rdata: exp_rd, len: 8'd3});
    wait_for(0, "cpu_done");
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'hC0DE_0000 | i;
    mem_arr[1] = 32'h1111_1111;
    mem_arr[2] = 32'h2222_2222;
    mem_arr[4] = 32'hDEAD_BEEF;
    reset = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    c1_rd = 1'b0; c1_addr = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    #1 reset = 1'b0;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    cpu_rd = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", stall, 0);

    do_cpu(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    do_cpu(1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF);
    do_cpu(1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
    do_cpu(1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h1234_5678);
    do_cpu(1'b1, 1'b0, 32'h24, 32'h0, 32'hCAFE_F00D);
    n0 = en_times.size();
    do_cpu(1'b1, 1'b0, 32'h4, 32'h0, 32'h1111_1111);
    do_cpu(1'b1, 1'b0, 32'h8, 32'h0, 32'h2222_2222);
    idle();
    chk("b2b_count", en_times.size() - n0, 2);
    if (en_times.size() >= n0 + 2) chk("b2b_spacing", en_times[n0+1] - en_times[n0], 4);

    // Reset while the access sits in WAIT.
    cpu_rd = 1'b1; cpu_addr = 32'h30;
    acc_q.push_back('{we: 1'b0, addr: 32'h30, wdata: 32'h0});
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0; #1;
    chk("wrst_mem_en", mem_en, 0);
    chk("wrst_mem_we", mem_we, 0);
    chk("wrst_mem_addr", mem_addr, 0);
    chk("wrst_mem_wdata", mem_wdata, 0);
    chk("wrst_cpu_rdata", cpu_rdata, 0);
    chk("wrst_stall", stall, 0);
    cpu_rd = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_cpu(1'b1, 1'b0, 32'h8, 32'h0, 32'h2222_2222);
    idle();

    // MEM_LAT=1 instance.
    c1_rd = 1'b1; c1_addr = 32'h40;
    q1.push_back('{rdata: 32'h5A5A_0040, len: 8'd2});
    wait_for(1, "lat1_done");
    @(posedge clk); #1;
    c1_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lat1_access_count", en1_cnt, 1);

`ifdef DBG_PORT_EN
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    acc_q.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0});
    acc_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
    acc_q.push_back('{we: 1'b0, addr: 32'h8, wdata: 32'h0});
    done_q.push_back('{rdata: 32'h1111_1111, len: 8'd3});
    dbg_q.push_back(32'hDEAD_BEEF);
    wait_for(0, "arb_cpu_first");
    @(posedge clk); #1;
    cpu_addr = 32'h8;
    done_q.push_back('{rdata: 32'h2222_2222, len: 8'd7});
    wait_for(2, "arb_dbg_done");
    @(posedge clk); #1;
    dbg_req = 1'b0;
    wait_for(0, "arb_cpu_second");
    @(posedge clk); #1;
    idle();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("acc_queue_empty", acc_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    chk("lat1_queue_empty", q1.size(), 0);
    chk("dbg_queue_empty", dbg_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
